// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM states and the output round/saturate helper for the FIR tap sequencer.
package fir_pkg;
  localparam int A_W = 18;
  localparam int B_W = 36;
  localparam int ACC_W = 68;
  localparam int OUT_W = 36;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
  // Round half-up at bit shift-1, arithmetic shift, clamp to signed OUT_W, sign-extend to ACC_W.
  function automatic logic signed [ACC_W-1:0] round_sat(input logic signed [ACC_W-1:0] x, input int shift);
    logic signed [ACC_W:0] one, hi, lo, t;
    one = (ACC_W+1)'(1);
    hi = (one <<< (OUT_W - 1)) - one;
    lo = -hi - one;
    t = ((ACC_W+1)'(x) + (one <<< (shift - 1))) >>> shift;
    return t > hi ? hi[ACC_W-1:0] : t < lo ? lo[ACC_W-1:0] : t[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/fir_mac_tap_sequencer_if.sv
// fir_mac_tap_sequencer_if: operand/accumulator link between the tap sequencer and the MAC wrapper.
interface fir_mac_tap_sequencer_if;
  import fir_pkg::*;
  logic signed [A_W-1:0] mac_a;
  logic signed [B_W-1:0] mac_b;
  logic mac_en;
  logic mac_clr;
  logic signed [ACC_W-1:0] mac_out;
  modport master (output mac_a, mac_b, mac_en, mac_clr, input mac_out);
  modport slave (input mac_a, mac_b, mac_en, mac_clr, output mac_out);
endinterface

// File: rtl/fir_sample_ring.sv
// fir_sample_ring: NTAPS-deep circular sample history; read port addressed as offset back from newest.
module fir_sample_ring import fir_pkg::*; #(
  parameter int NTAPS = 16
) (
  input logic clock,
  input logic reset,
  input logic we,
  input logic adv,
  input logic signed [B_W-1:0] wdata,
  input logic [$clog2(NTAPS)-1:0] offset,
  output logic signed [B_W-1:0] rdata
);
  localparam int AW = $clog2(NTAPS);
  logic signed [B_W-1:0] ring_q [NTAPS];
  logic signed [B_W-1:0] ring_d [NTAPS];
  logic [AW-1:0] wptr_q, wptr_d;
  always_comb begin
    ring_d = ring_q;
    if (we) ring_d[wptr_q] = wdata;
    wptr_d = adv ? wptr_q + 1'b1 : wptr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ring_q <= '{default: '0};
      wptr_q <= '0;
    end else begin
      ring_q <= ring_d;
      wptr_q <= wptr_d;
    end
  end
  assign rdata = ring_q[wptr_q - offset];
endmodule

// File: rtl/fir_mac_tap_sequencer.sv
// fir_mac_tap_sequencer: per input sample, streams NTAPS coef/sample pairs to the MAC and captures the sum.
// Define FIR_ROUND_SAT_EN to round, shift by OUT_SHIFT and saturate the captured sum to 36 bits.
module fir_mac_tap_sequencer import fir_pkg::*; #(
  parameter int NTAPS = 16,
  parameter int MAC_LAT = 3,
  parameter int OUT_SHIFT = 17
) (
  input logic clock,
  input logic reset,
  input logic signed [B_W-1:0] din,
  input logic din_valid,
  output logic din_ready,
  input logic coef_we,
  input logic [$clog2(NTAPS)-1:0] coef_waddr,
  input logic signed [A_W-1:0] coef_wdata,
  fir_mac_tap_sequencer_if.master mac,
  output logic signed [ACC_W-1:0] dout,
  output logic dout_valid
);
  localparam int AW = $clog2(NTAPS);
  localparam int CW = $clog2(MAC_LAT + 1);
  if (NTAPS < 2 || NTAPS > 64 || (NTAPS & (NTAPS - 1)) != 0 || MAC_LAT < 1 ||
      OUT_SHIFT < 1 || OUT_SHIFT >= ACC_W) begin : g_cfg_check
    $error("fir_mac_tap_sequencer: unsupported parameter set");
  end
  state_t state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [A_W-1:0] coef_q [NTAPS];
  logic signed [A_W-1:0] coef_d [NTAPS];
  logic signed [A_W-1:0] mac_a_q, mac_a_d;
  logic signed [B_W-1:0] mac_b_q, mac_b_d;
  logic mac_en_q, mac_en_d, mac_clr_q, mac_clr_d;
  logic signed [ACC_W-1:0] dout_q, dout_d, fin;
  logic dout_valid_q, dout_valid_d;
  logic signed [B_W-1:0] ring_rd;
  logic accept;
  assign din_ready = state_q == IDLE && !reset;
  assign accept = din_valid && din_ready;
  fir_sample_ring #(.NTAPS(NTAPS)) u_ring (
    .clock (clock),
    .reset (reset),
    .we    (accept),
    .adv   (state_q == OUT),
    .wdata (din),
    .offset(k_q),
    .rdata (ring_rd)
  );
`ifdef FIR_ROUND_SAT_EN
  assign fin = round_sat(mac.mac_out, OUT_SHIFT);
`else
  assign fin = mac.mac_out;
`endif
  // Operands hold through DRAIN so the MAC inputs stay quiet until the next sample.
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    cnt_d = cnt_q;
    coef_d = coef_q;
    if (coef_we) coef_d[coef_waddr] = coef_wdata;
    mac_en_d = state_q == RUN;
    mac_clr_d = state_q == RUN && k_q == '0;
    mac_a_d = state_q == RUN ? coef_q[k_q] : mac_a_q;
    mac_b_d = state_q == RUN ? ring_rd : mac_b_q;
    dout_valid_d = state_q == OUT;
    dout_d = state_q == OUT ? fin : dout_q;
    case (state_q)
      IDLE: begin
        state_d = accept ? RUN : IDLE;
        k_d = '0;
      end
      RUN: begin
        k_d = k_q + 1'b1;
        state_d = k_q == AW'(NTAPS - 1) ? DRAIN : RUN;
        cnt_d = CW'(MAC_LAT);
      end
      DRAIN: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? OUT : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      cnt_q <= '0;
      coef_q <= '{default: '0};
      mac_a_q <= '0;
      mac_b_q <= '0;
      mac_en_q <= 1'b0;
      mac_clr_q <= 1'b0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      coef_q <= coef_d;
      mac_a_q <= mac_a_d;
      mac_b_q <= mac_b_d;
      mac_en_q <= mac_en_d;
      mac_clr_q <= mac_clr_d;
      dout_q <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end
  assign mac.mac_a = mac_a_q;
  assign mac.mac_b = mac_b_q;
  assign mac.mac_en = mac_en_q;
  assign mac.mac_clr = mac_clr_q;
  assign dout = dout_q;
  assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_fir_mac_tap_sequencer.sv
// tb_fir_mac_tap_sequencer: directed checks of a 4-tap and a 16-tap sequencer against a behavioural MAC.
module tb_fir_mac_tap_sequencer;
  import fir_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic signed [35:0] din = '0;
  logic dv4 = 1'b0, dv16 = 1'b0;
  logic coef_we = 1'b0;
  logic [3:0] coef_waddr = '0;
  logic signed [17:0] coef_wdata = '0;
  logic dr4, dr16, dvo4, dvo16;
  logic signed [67:0] dout4, dout16;
  logic signed [67:0] p4 [3];
  logic signed [67:0] p16 [3];
  int tests = 0, fails = 0;

  fir_mac_tap_sequencer_if m4 ();
  fir_mac_tap_sequencer_if m16 ();

  fir_mac_tap_sequencer #(.NTAPS(4), .MAC_LAT(3), .OUT_SHIFT(17)) dut4 (
    .clock(clock), .reset(reset), .din(din), .din_valid(dv4), .din_ready(dr4),
    .coef_we(coef_we), .coef_waddr(coef_waddr[1:0]), .coef_wdata(coef_wdata),
    .mac(m4), .dout(dout4), .dout_valid(dvo4));

  fir_mac_tap_sequencer #(.NTAPS(16), .MAC_LAT(3), .OUT_SHIFT(17)) dut16 (
    .clock(clock), .reset(reset), .din(din), .din_valid(dv16), .din_ready(dr16),
    .coef_we(coef_we), .coef_waddr(coef_waddr), .coef_wdata(coef_wdata),
    .mac(m16), .dout(dout16), .dout_valid(dvo16));

  always #5 clock = ~clock;

  function automatic logic signed [67:0] mul(input logic signed [17:0] a, input logic signed [35:0] b);
    logic signed [67:0] aa, bb;
    aa = a;
    bb = b;
    return aa * bb;
  endfunction

  // MAC model: accumulator register plus two output stages, so the final sum lands MAC_LAT=3 cycles after the last issue.
  always @(posedge clock) begin
    if (m4.mac_en) p4[0] <= m4.mac_clr ? mul(m4.mac_a, m4.mac_b) : p4[0] + mul(m4.mac_a, m4.mac_b);
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    if (m16.mac_en) p16[0] <= m16.mac_clr ? mul(m16.mac_a, m16.mac_b) : p16[0] + mul(m16.mac_a, m16.mac_b);
    p16[1] <= p16[0];
    p16[2] <= p16[1];
  end
  assign m4.mac_out = p4[2];
  assign m16.mac_out = p16[2];

  function automatic logic signed [67:0] exp_out(input logic signed [67:0] raw);
`ifdef FIR_ROUND_SAT_EN
    logic signed [68:0] w;
    w = raw;
    w = (w + 69'sd65536) >>> 17;
    if (w > 69'sd34359738367) return 68'sd34359738367;
    if (w < -69'sd34359738368) return -68'sd34359738368;
    return w[67:0];
`else
    return raw;
`endif
  endfunction

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic wr_coef(input int idx, input logic signed [17:0] v);
    coef_we = 1'b1;
    coef_waddr = 4'(idx);
    coef_wdata = v;
    tick;
    coef_we = 1'b0;
  endtask

  task automatic run(input bit big, input logic signed [35:0] s, output logic signed [67:0] got,
                     output int lat, output bit to);
    int n = 0;
    while (!(big ? dr16 : dr4) && n < 200) begin tick; n++; end
    din = s;
    if (big) dv16 = 1'b1; else dv4 = 1'b1;
    tick;
    dv4 = 1'b0;
    dv16 = 1'b0;
    lat = 1;
    while (!(big ? dvo16 : dvo4) && lat < 200) begin tick; lat++; end
    got = big ? dout16 : dout4;
    to = lat >= 200 || n >= 200;
  endtask

  task automatic test_reset;
    tick;
    tick;
    tests += 7;
    if (dr4 !== 1'b0) begin fails++; $display("FAIL reset din_ready got %0b want 0", dr4); end
    if (m4.mac_en !== 1'b0) begin fails++; $display("FAIL reset mac_en got %0b want 0", m4.mac_en); end
    if (m4.mac_clr !== 1'b0) begin fails++; $display("FAIL reset mac_clr got %0b want 0", m4.mac_clr); end
    if (m4.mac_a !== '0) begin fails++; $display("FAIL reset mac_a got %0d want 0", m4.mac_a); end
    if (m4.mac_b !== '0) begin fails++; $display("FAIL reset mac_b got %0d want 0", m4.mac_b); end
    if (dout4 !== '0) begin fails++; $display("FAIL reset dout got %0d want 0", dout4); end
    if (dvo4 !== 1'b0) begin fails++; $display("FAIL reset dout_valid got %0b want 0", dvo4); end
    reset = 1'b0;
    tick;
    tests++;
    if (dr4 !== 1'b1) begin fails++; $display("FAIL post_reset din_ready got %0b want 1", dr4); end
  endtask

  task automatic test_impulse;
    logic signed [17:0] c [4] = '{18'sd3, -18'sd2, 18'sd5, 18'sd7};
    logic signed [67:0] e [5] = '{68'sd3, -68'sd2, 68'sd5, 68'sd7, 68'sd0};
    logic signed [67:0] got;
    int lat;
    bit to;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) wr_coef(k, c[k]);
    for (int i = 0; i < 5; i++) begin
      run(1'b0, i == 0 ? 36'sd1 : 36'sd0, got, lat, to);
      tests += 2;
      if (to) begin fails++; $display("FAIL impulse%0d timeout after %0d cycles", i, lat); end
      if (got !== exp_out(e[i])) begin fails++; $display("FAIL impulse%0d dout got %0d want %0d", i, got, exp_out(e[i])); end
      if (i == 0) begin
        tests++;
        if (lat != 9) begin fails++; $display("FAIL impulse latency got %0d want 9", lat); end
      end
    end
  endtask

  task automatic test_wrap;
    logic signed [67:0] e [5] = '{68'sd1, 68'sd3, 68'sd6, 68'sd10, 68'sd14};
    logic signed [67:0] got;
    int lat;
    bit to;
    for (int k = 0; k < 4; k++) wr_coef(k, 18'sd1);
    for (int i = 0; i < 5; i++) begin
      run(1'b0, 36'(i + 1), got, lat, to);
      tests++;
      if (to || got !== exp_out(e[i])) begin
        fails++;
        $display("FAIL wrap%0d dout got %0d want %0d (timeout=%0b)", i, got, exp_out(e[i]), to);
      end
    end
  endtask

  task automatic test_back_to_back;
    int last = -1, rdy = 0, outs = 0;
    bit took;
    wr_coef(0, 18'sd1);
    for (int k = 1; k < 4; k++) wr_coef(k, 18'sd0);
    din = 36'sd100;
    dv4 = 1'b1;
    for (int i = 0; i < 45; i++) begin
      took = dr4;
      if (took) begin
        rdy++;
        if (last >= 0) begin
          tests++;
          if (i - last != 9) begin fails++; $display("FAIL b2b accept gap got %0d want 9", i - last); end
        end
        last = i;
      end
      if (dvo4) begin
        tests++;
        if (dout4 !== exp_out(68'(100 + outs))) begin
          fails++;
          $display("FAIL b2b out%0d dout got %0d want %0d", outs, dout4, exp_out(68'(100 + outs)));
        end
        outs++;
      end
      tick;
      if (took) din = din + 36'sd1;
    end
    dv4 = 1'b0;
    tests += 2;
    if (rdy != 5) begin fails++; $display("FAIL b2b ready cycles got %0d want 5", rdy); end
    if (outs != 4) begin fails++; $display("FAIL b2b outputs got %0d want 4", outs); end
  endtask

  task automatic test_reset_mid_run;
    logic signed [67:0] got;
    int lat;
    bit to, seen = 1'b0;
    din = 36'sd5;
    dv4 = 1'b1;
    tick;
    dv4 = 1'b0;
    tick;
    tick;
    tests++;
    if (m4.mac_en !== 1'b1) begin fails++; $display("FAIL midrst mac_en before got %0b want 1", m4.mac_en); end
    reset = 1'b1;
    tick;
    tests += 2;
    if (m4.mac_en !== 1'b0) begin fails++; $display("FAIL midrst mac_en after got %0b want 0", m4.mac_en); end
    if (dr4 !== 1'b0) begin fails++; $display("FAIL midrst din_ready in reset got %0b want 0", dr4); end
    reset = 1'b0;
    tick;
    tests++;
    if (dr4 !== 1'b1) begin fails++; $display("FAIL midrst din_ready after got %0b want 1", dr4); end
    for (int i = 0; i < 15; i++) begin
      seen |= dvo4;
      tick;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL midrst dout_valid got 1 want 0"); end
    wr_coef(0, 18'sd1);
    for (int k = 1; k < 4; k++) wr_coef(k, 18'sd0);
    run(1'b0, 36'sd9, got, lat, to);
    tests++;
    if (to || got !== exp_out(68'sd9)) begin fails++; $display("FAIL midrst dout got %0d want %0d (timeout=%0b)", got, exp_out(68'sd9), to); end
    for (int k = 1; k < 4; k++) wr_coef(k, 18'sd1);
    run(1'b0, 36'sd0, got, lat, to);
    tests++;
    if (to || got !== exp_out(68'sd9)) begin fails++; $display("FAIL midrst history got %0d want %0d (timeout=%0b)", got, exp_out(68'sd9), to); end
  endtask

  task automatic test_coef_write;
    logic signed [67:0] got;
    int lat = 0;
    bit to;
    for (int k = 1; k < 4; k++) wr_coef(k, 18'sd0);
    wr_coef(0, 18'sd4);
    din = 36'sd2;
    dv4 = 1'b1;
    tick;
    dv4 = 1'b0;
    coef_we = 1'b1;
    coef_waddr = 4'd0;
    coef_wdata = 18'sd6;
    tick;
    coef_we = 1'b0;
    tests += 2;
    if (m4.mac_a !== 18'sd4) begin fails++; $display("FAIL coefwr same-cycle mac_a got %0d want 4", m4.mac_a); end
    if (m4.mac_clr !== 1'b1) begin fails++; $display("FAIL coefwr mac_clr got %0b want 1", m4.mac_clr); end
    while (!dvo4 && lat < 200) begin tick; lat++; end
    tests++;
    if (lat >= 200 || dout4 !== exp_out(68'sd8)) begin fails++; $display("FAIL coefwr dout got %0d want %0d", dout4, exp_out(68'sd8)); end
    run(1'b0, 36'sd2, got, lat, to);
    tests++;
    if (to || got !== exp_out(68'sd12)) begin fails++; $display("FAIL coefwr new coef got %0d want %0d (timeout=%0b)", got, exp_out(68'sd12), to); end
  endtask

  task automatic test_wide_sum;
    logic signed [67:0] got, first, e52, e56;
    int lat, lat0 = 0;
    bit to, anyto = 1'b0;
    e52 = 68'sd1 <<< 52;
    e56 = 68'sd1 <<< 56;
    first = '0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) wr_coef(k, -18'sd131072);
    for (int i = 0; i < 16; i++) begin
      run(1'b1, -36'sd34359738368, got, lat, to);
      anyto |= to;
      if (i == 0) begin first = got; lat0 = lat; end
    end
    tests += 4;
    if (anyto) begin fails++; $display("FAIL wide timeout"); end
    if (lat0 != 21) begin fails++; $display("FAIL wide latency got %0d want 21", lat0); end
    if (first !== exp_out(e52)) begin fails++; $display("FAIL wide first got %0d want %0d", first, exp_out(e52)); end
    if (got !== exp_out(e56)) begin fails++; $display("FAIL wide full got %0d want %0d", got, exp_out(e56)); end
  endtask

  initial begin
    test_reset;
    test_impulse;
    test_wrap;
    test_back_to_back;
    test_reset_mid_run;
    test_coef_write;
    test_wide_sum;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
